// File: rtl/perf_pkg.sv
// perf_pkg: shared definitions for the performance-counter block.
//   - register word indices (req_addr[4:2])
//   - CTRL bit positions
//   - perf_ev_e: counter index, in STATUS bit / snapshot word order
//   - resp_t: response payload (read data + error flag)
//   - rf_rd_amount(): saturates the 2-bit register-file read strobe to 0..2
package perf_pkg;

    localparam int NUM_EV = 6;

    localparam logic [2:0] W_CTRL          = 3'd0;
    localparam logic [2:0] W_STATUS        = 3'd1;
    localparam logic [2:0] W_SNAP_CYCLE    = 3'd2;
    localparam logic [2:0] W_SNAP_INSTR    = 3'd3;
    localparam logic [2:0] W_SNAP_MEM_RD   = 3'd4;
    localparam logic [2:0] W_SNAP_MEM_WR   = 3'd5;
    localparam logic [2:0] W_SNAP_RF_RD    = 3'd6;
    localparam logic [2:0] W_SNAP_RF_WR    = 3'd7;

    localparam int CTRL_ENABLE   = 0;
    localparam int CTRL_CLEAR    = 1;
    localparam int CTRL_SNAPSHOT = 2;

    typedef enum logic [2:0] {
        EV_CYCLE  = 3'd0,
        EV_INSTR  = 3'd1,
        EV_MEM_RD = 3'd2,
        EV_MEM_WR = 3'd3,
        EV_RF_RD  = 3'd4,
        EV_RF_WR  = 3'd5
    } perf_ev_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    // A strobe value of 3 is not a legal read count; it counts as 2.
    function automatic logic [1:0] rf_rd_amount(input logic [1:0] n);
        return (n == 2'd3) ? 2'd2 : n;
    endfunction

endpackage

// File: rtl/perf_counter.sv
// perf_counter: one wrapping event counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc[1:0]     : amount to add this cycle (0..2)
//   en           : counting enabled
//   clr          : synchronous clear; wins over any increment this cycle
//   value        : current count
//   ovf          : combinational pulse, high in the cycle whose edge wraps the count
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       inc,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] value,
    output logic             ovf
);

    logic [CNT_W-1:0] value_q, value_d;
    logic [CNT_W:0]   sum;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        sum     = {1'b0, value_q} + {{(CNT_W-1){1'b0}}, inc};
        value_d = value_q;
        ovf     = 1'b0;
        if (clr) begin
            value_d = '0;
        end else if (en) begin
            value_d = sum[CNT_W-1:0];
            ovf     = sum[CNT_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/perf_counter_unit.sv
// perf_counter_unit: six event counters served over a valid/ready register port.
//   clk, reset_n            : clock, asynchronous active-low reset
//   ev_*                    : per-cycle event strobes from the core
//   req_valid/req_ready     : request handshake; req_we, req_addr, req_wdata payload
//   resp_valid/resp_ready   : response handshake; resp_rdata, resp_err payload
// Words: CTRL, STATUS (sticky W1C overflow flags), six read-only snapshots.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ev_instr,
    input  logic        ev_mem_rd,
    input  logic        ev_mem_wr,
    input  logic [1:0]  ev_rf_rd,
    input  logic        ev_rf_wr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [4:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    logic                   enable_q, enable_d;
    logic [NUM_EV-1:0]      status_q, status_d;
    logic [CNT_W-1:0]       snap_q [NUM_EV];
    logic [CNT_W-1:0]       snap_d [NUM_EV];
    logic                   resp_valid_q, resp_valid_d;
    resp_t                  resp_q, resp_d;

    logic [CNT_W-1:0]       live [NUM_EV];
    logic [NUM_EV-1:0]      ovf;
    logic [1:0]             inc  [NUM_EV];

    logic                   accept;
    logic [2:0]             word;
    logic                   ctrl_wr, status_wr, clr, snap_req;
    logic [31:0]            rd_word;
    logic                   unused_bits;

    assign unused_bits = ^{req_addr[1:0], req_wdata[31:NUM_EV]};

    // One outstanding response; a new request may ride the consuming edge.
    assign req_ready = !resp_valid_q || resp_ready;
    assign accept    = req_valid && req_ready;
    assign word      = req_addr[4:2];
    assign ctrl_wr   = accept && req_we && (word == W_CTRL);
    assign status_wr = accept && req_we && (word == W_STATUS);
    assign clr       = ctrl_wr && req_wdata[CTRL_CLEAR];
    assign snap_req  = ctrl_wr && req_wdata[CTRL_SNAPSHOT];

    always_comb begin
        inc[EV_CYCLE]  = 2'd1;
        inc[EV_INSTR]  = {1'b0, ev_instr};
        inc[EV_MEM_RD] = {1'b0, ev_mem_rd};
        inc[EV_MEM_WR] = {1'b0, ev_mem_wr};
        inc[EV_RF_RD]  = rf_rd_amount(ev_rf_rd);
        inc[EV_RF_WR]  = {1'b0, ev_rf_wr};
    end

    // Counters see the ENABLE value from before this cycle's write.
    for (genvar i = 0; i < NUM_EV; i++) begin : g_cnt
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (clk),
            .reset_n (reset_n),
            .inc     (inc[i]),
            .en      (enable_q),
            .clr     (clr),
            .value   (live[i]),
            .ovf     (ovf[i])
        );
    end

    always_comb begin
        enable_d = enable_q;
        if (ctrl_wr) begin
            enable_d = req_wdata[CTRL_ENABLE];
        end

        // Clear first, then OR in new wraps: a simultaneous set wins.
        status_d = status_q;
        if (status_wr) begin
            status_d = status_q & ~req_wdata[NUM_EV-1:0];
        end
        status_d = status_d | ovf;

        // Live values are pre-increment and pre-clear at this edge.
        for (int i = 0; i < NUM_EV; i++) begin
            snap_d[i] = snap_q[i];
            if (snap_req) begin
                snap_d[i] = live[i];
            end
        end
    end

    // Read data reflects state after the acceptance edge, hence the _d values.
    always_comb begin
        rd_word = '0;
        case (word)
            W_CTRL:   rd_word[CTRL_ENABLE]  = enable_d;
            W_STATUS: rd_word[NUM_EV-1:0]   = status_d;
            default:  rd_word[CNT_W-1:0]    = snap_d[word - W_SNAP_CYCLE];
        endcase
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_d       = resp_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_d.rdata = req_we ? 32'd0 : rd_word;
            resp_d.err   = req_we && (word >= W_SNAP_CYCLE);
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q     <= 1'b1;
            status_q     <= '0;
            // NOTE: the snapshot bank is architecturally visible and reads 0 after reset, so it is reset like any other register.
            for (int i = 0; i < NUM_EV; i++) begin
                snap_q[i] <= '0;
            end
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
        end else begin
            enable_q     <= enable_d;
            status_q     <= status_d;
            for (int i = 0; i < NUM_EV; i++) begin
                snap_q[i] <= snap_d[i];
            end
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_q.rdata;
    assign resp_err   = resp_q.err;

endmodule

// File: tb/tb_perf_counter_unit.sv
// Testbench for perf_counter_unit (CNT_W = 8 so wraps are reachable).
// A reference model advances counters per clock edge with plain arithmetic and
// queues the expected response of every accepted request; a monitor compares
// whatever the DUT presents against the head of that queue.
module tb_perf_counter_unit;
    import perf_pkg::*;

    localparam int     CNT_W = 8;
    localparam longint MOD   = 64'd1 << CNT_W;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ev_instr = 1'b0, ev_mem_rd = 1'b0, ev_mem_wr = 1'b0, ev_rf_wr = 1'b0;
    logic [1:0]  ev_rf_rd = 2'd0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [4:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b1;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    always #5 clk = ~clk;

    perf_counter_unit #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ev_instr   (ev_instr),
        .ev_mem_rd  (ev_mem_rd),
        .ev_mem_wr  (ev_mem_wr),
        .ev_rf_rd   (ev_rf_rd),
        .ev_rf_wr   (ev_rf_wr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    int n_vec  = 0;
    int n_miss = 0;
    int pops   = 0;
    int cyc    = 0;
    int last_acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    longint          m_cnt  [NUM_EV];
    longint          m_snap [NUM_EV];
    bit [NUM_EV-1:0] m_status;
    bit              m_en;
    bit              m_pending;
    resp_t           exp_q [$];

    always @(posedge clk or negedge reset_n) begin : model
        longint          old_v [NUM_EV];
        int              amt   [NUM_EV];
        bit [NUM_EV-1:0] ov;
        bit              acc, ctrl_wr, clr, snp;
        int              word;
        resp_t           r;
        if (!reset_n) begin
            for (int i = 0; i < NUM_EV; i++) begin
                m_cnt[i]  = 0;
                m_snap[i] = 0;
            end
            m_status  = '0;
            m_en      = 1'b1;
            m_pending = 1'b0;
            exp_q.delete();
        end else begin
            amt[0] = 1;
            amt[1] = int'(ev_instr);
            amt[2] = int'(ev_mem_rd);
            amt[3] = int'(ev_mem_wr);
            amt[4] = (ev_rf_rd > 2) ? 2 : int'(ev_rf_rd);
            amt[5] = int'(ev_rf_wr);
            acc     = req_valid && (!m_pending || resp_ready);
            word    = int'(req_addr[4:2]);
            ctrl_wr = acc && req_we && word == 0;
            clr     = ctrl_wr && req_wdata[1];
            snp     = ctrl_wr && req_wdata[2];
            ov      = '0;
            for (int i = 0; i < NUM_EV; i++) begin
                old_v[i] = m_cnt[i];
                if (clr) begin
                    m_cnt[i] = 0;
                end else if (m_en) begin
                    m_cnt[i] = m_cnt[i] + amt[i];
                    if (m_cnt[i] >= MOD) begin
                        m_cnt[i] = m_cnt[i] - MOD;
                        ov[i]    = 1'b1;
                    end
                end
            end
            if (snp) begin
                for (int i = 0; i < NUM_EV; i++) m_snap[i] = old_v[i];
            end
            if (acc && req_we && word == 1) m_status = m_status & ~req_wdata[NUM_EV-1:0];
            m_status = m_status | ov;
            if (ctrl_wr) m_en = req_wdata[0];
            if (acc) begin
                r.rdata = 32'd0;
                r.err   = 1'b0;
                if (req_we) begin
                    r.err = (word >= 2);
                end else if (word == 0) begin
                    r.rdata = {31'd0, m_en};
                end else if (word == 1) begin
                    r.rdata = {26'd0, m_status};
                end else begin
                    r.rdata = 32'(m_snap[word-2]);
                end
                exp_q.push_back(r);
                m_pending = 1'b1;
            end else if (resp_ready) begin
                m_pending = 1'b0;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            check("resp_valid", resp_valid, m_pending);
            check("req_ready", req_ready, !m_pending || resp_ready);
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", resp_valid, 1'b0);
                end else begin
                    check("resp_rdata", resp_rdata, exp_q[0].rdata);
                    check("resp_err", resp_err, exp_q[0].err);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        pops++;
                    end
                end
            end
        end
    end

    // Issue one request, wait for acceptance (bounded), return the response
    // sampled at the falling edge after the acceptance edge.
    task automatic do_req(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        @(negedge clk);
        while (!req_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", req_ready, 1'b1);
            req_valid = 1'b0;
            rdata     = '0;
            err       = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        last_acc_cyc = cyc;
        req_valid    = 1'b0;
        @(negedge clk);
        check("resp_latency", resp_valid, 1'b1);
        rdata = resp_rdata;
        err   = resp_err;
    endtask

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [31:0] d;
        logic        e;
        int          c_clr, p0;

        // Reset state
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_resp_err", resp_err, 1'b0);
        check("rst_req_ready", req_ready, 1'b1);

        do_req(1'b0, 5'h00, 32'd0, d, e);  check("ctrl_reset", d, 32'h1);
        do_req(1'b0, 5'h04, 32'd0, d, e);  check("status_reset", d, 32'h0);
        do_req(1'b0, 5'h08, 32'd0, d, e);  check("snap_cycle_reset", d, 32'h0);

        // 40 retired instructions in 100 cycles, then snapshot
        do_req(1'b1, 5'h00, 32'h3, d, e);
        check("ctrl_write_err", e, 1'b0);
        c_clr = last_acc_cyc;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            ev_instr = (i < 40);
        end
        do_req(1'b1, 5'h00, 32'h5, d, e);
        p0 = last_acc_cyc;
        do_req(1'b0, 5'h0C, 32'd0, d, e);  check("snap_instr_40", d, 32'd40);
        do_req(1'b0, 5'h08, 32'd0, d, e);
        check("snap_cycle_live", d, 32'((p0 - c_clr - 1) % int'(MOD)));

        // rf_rd: 2 ten times, 3 (saturates to 2) once
        do_req(1'b1, 5'h00, 32'h3, d, e);
        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1;
            ev_rf_rd = (i < 10) ? 2'd2 : 2'd3;
        end
        @(posedge clk); #1;
        ev_rf_rd = 2'd0;
        do_req(1'b1, 5'h00, 32'h5, d, e);
        do_req(1'b0, 5'h18, 32'd0, d, e);  check("snap_rf_rd_22", d, 32'd22);

        // Cycle counter wrap: snapshot 260 edges after clear sees 259 mod 256
        do_req(1'b1, 5'h04, 32'h3F, d, e);
        do_req(1'b1, 5'h00, 32'h3, d, e);
        repeat (259) @(posedge clk);
        #1;
        do_req(1'b1, 5'h00, 32'h5, d, e);
        do_req(1'b0, 5'h08, 32'd0, d, e);  check("snap_cycle_wrap", d, 32'd3);
        do_req(1'b0, 5'h04, 32'd0, d, e);  check("status_ovf_cycle", d, 32'h1);
        do_req(1'b1, 5'h04, 32'h1, d, e);
        do_req(1'b0, 5'h04, 32'd0, d, e);  check("status_w1c", d, 32'h0);

        // Backpressure: one request accepted, response held for 5 cycles
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h00;
        p0         = pops;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_rdata_stable", resp_rdata, 32'h1);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("bp_transfers", 32'(pops - p0), 32'd4);

        // Write to a read-only snapshot word
        do_req(1'b1, 5'h0C, 32'hFF, d, e);
        check("ro_write_err", e, 1'b1);
        check("ro_write_rdata", d, 32'd0);
        do_req(1'b0, 5'h0C, 32'd0, d, e);  check("ro_write_unchanged", d, 32'd0);

        // CLEAR with a simultaneous mem write event
        ev_mem_wr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_req(1'b1, 5'h00, 32'h3, d, e);
        ev_mem_wr = 1'b0;
        do_req(1'b1, 5'h00, 32'h5, d, e);
        do_req(1'b0, 5'h14, 32'd0, d, e);  check("clear_drops_event", d, 32'd0);
        do_req(1'b0, 5'h08, 32'd0, d, e);  check("cycle_after_clear", d, 32'd1);

        // Reset with a response pending
        do_req(1'b1, 5'h00, 32'h0, d, e);
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 5'h08;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        check("rst_abort_valid", resp_valid, 1'b0);
        check("rst_abort_rdata", resp_rdata, 32'd0);
        check("rst_abort_ready", req_ready, 1'b1);
        resp_ready = 1'b1;
        @(posedge clk); #2 reset_n = 1'b1;
        do_req(1'b0, 5'h00, 32'd0, d, e);  check("ctrl_after_reset", d, 32'h1);
        do_req(1'b0, 5'h08, 32'd0, d, e);  check("snap_after_reset", d, 32'h0);

        // Randomized traffic, checked entirely by the scoreboard
        for (int i = 0; i < 800; i++) begin
            @(posedge clk); #1;
            ev_instr   = 1'($urandom_range(0, 1));
            ev_mem_rd  = 1'($urandom_range(0, 1));
            ev_mem_wr  = 1'($urandom_range(0, 1));
            ev_rf_rd   = 2'($urandom_range(0, 3));
            ev_rf_wr   = 1'($urandom_range(0, 1));
            resp_ready = ($urandom_range(0, 3) != 0);
            req_valid  = 1'($urandom_range(0, 1));
            req_we     = ($urandom_range(0, 2) == 0);
            req_addr   = 5'($urandom_range(0, 31));
            req_wdata  = $urandom;
            if (req_we && req_addr[4:2] == 3'd0) req_wdata[0] = ($urandom_range(0, 7) != 0);
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        {ev_instr, ev_mem_rd, ev_mem_wr, ev_rf_wr} = '0;
        ev_rf_rd   = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
